seq_logic_unit: RTL
===================

# seq_logic_unit

Parametrised, multi-cycle bitwise logic unit: the successor to the single-function 16-bit combinational XOR slice. Performs one of eight bitwise operations on WIDTH-bit operands, processing SLICE bits per clock under a start/ready/done handshake. Produces registered result and Z/N/C/V flags for the ALU flag mux. An optional parity flag is available.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle; NSLICE = WIDTH/SLICE; SLICE == WIDTH is legal (NSLICE = 1).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when ready = 1.
- op  in  3  operation select; latched with start.
- a, b  in  WIDTH  operands; latched with start.
- ready  out  1  high in IDLE and DONE states.
- busy  out  1  high in RUN state.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  registered result of the last completed operation.
- Z, N, C, V  out  1  registered flags of the last completed operation.
- P  out  1  parity flag; see Configuration.

## Operation
- op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 XNOR
  - 100 NOT a (b ignored)
  - 101 NAND
  - 110 NOR
  - 111 PASS b
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, op into working registers, clears the slice counter and zero accumulator, then goes to RUN.
  - RUN: each cycle computes slice k (bits k·SLICE+SLICE-1 .. k·SLICE, LSB slice first) into the working result; ORs the slice into the zero accumulator; increments k. After slice NSLICE-1, copies the working result to result, updates flags, then goes to DONE.
  - DONE: done=1. If start=1, behaves exactly as IDLE accepting a new request (goes to RUN); otherwise goes to IDLE.
- start while busy is ignored; it is not queued. Changes on a, b, op during RUN have no effect.
- Flags:
  - Z = 1 iff all WIDTH result bits are 0.
  - N = result[WIDTH-1].
  - C = 0 and V = 0 always.
- result and flags are stable from done until the next done. They never show partial slices.
- Illegal WIDTH % SLICE ≠ 0: elaboration-time error.

## Timing
- Reset values: result=0, Z=N=C=V=P=0, done=0, busy=0, state IDLE (so ready=1).
- Reset asserted mid-operation aborts immediately. State returns to IDLE, working registers clear, and result/flags clear to 0. No done pulse is produced.
- The start accepted at edge t is processed in RUN on edges t+1 .. t+NSLICE. result and flags update at edge t+NSLICE; done is high from t+NSLICE to t+NSLICE+1.
- Latency is NSLICE cycles from the accepting edge to done. Back-to-back throughput is one operation per NSLICE+1 cycles (start held high in DONE).
- ready, busy and done decode directly from state registers, with no combinational path from inputs.

## Configuration
- SEQ_LOGIC_UNIT_PARITY_EN defined: P = XOR-reduction of result (1 = odd number of ones). P is registered alongside the other flags and updated at the same edge.
- Not defined: P is tied to 0 and no parity logic is generated. All other behaviour is identical.

## Test plan
- Reset then idle: after rst_n rises, ready=1, busy=0, done=0, result=0x0000, Z=N=C=V=P=0.
- XOR, default parameters: a=0xF0F0, b=0xFF00, op=010 → done exactly 4 cycles after the accepting edge; result=0x0FF0, Z=0, N=0, C=V=0; P=0 with macro defined.
- Zero and negative: XNOR a=0x1234, b=0xEDCB → result=0x0000, Z=1. Then NOT a=0x0001 → result=0xFFFE, N=1, Z=0.
- Back-to-back and ignored start: hold start=1 in DONE to issue AND 0xFFFF & 0x8001 immediately → result=0x8001, N=1, done 4 cycles later. A start pulse while busy produces no extra done.
- Reset mid-RUN: assert rst_n=0 two cycles into an OR operation → result=0, no done pulse. After release, a fresh PASS b=0x00A5 completes with result=0x00A5.
- Parameter sweep: WIDTH=32/SLICE=8 and WIDTH=8/SLICE=8 → latency 4 and 1 cycles respectively. Random ops checked against a golden bitwise model, including the Z and N flags.

Source files
------------

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: SLICE bits per clock under a start/ready/done handshake.
// Optional parity flag P is built when SEQ_LOGIC_UNIT_PARITY_EN is defined.
module seq_logic_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             P
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [2:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SLICE-1:0] zacc_q, zacc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d;
  logic [SLICE-1:0] slice_res;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
  logic             p_q, p_d;
`endif

  // Operands shift right each RUN cycle, so the current slice is always the low SLICE bits.
  always_comb begin
    slice_res = '0;
    case (op_q)
      3'b000:  slice_res = a_q[SLICE-1:0] & b_q[SLICE-1:0];
      3'b001:  slice_res = a_q[SLICE-1:0] | b_q[SLICE-1:0];
      3'b010:  slice_res = a_q[SLICE-1:0] ^ b_q[SLICE-1:0];
      3'b011:  slice_res = ~(a_q[SLICE-1:0] ^ b_q[SLICE-1:0]);
      3'b100:  slice_res = ~a_q[SLICE-1:0];
      3'b101:  slice_res = ~(a_q[SLICE-1:0] & b_q[SLICE-1:0]);
      3'b110:  slice_res = ~(a_q[SLICE-1:0] | b_q[SLICE-1:0]);
      default: slice_res = b_q[SLICE-1:0];
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    work_d  = work_q;
    zacc_d  = zacc_q;
    k_d     = k_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
    p_d     = p_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          work_d  = '0;
          zacc_d  = '0;
          k_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d    = a_q >> SLICE;
        b_d    = b_q >> SLICE;
        // New slice enters at the top; after NSLICE shifts slice 0 sits at the LSBs.
        work_d = WIDTH'({slice_res, work_q} >> SLICE);
        zacc_d = zacc_q | slice_res;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(NSLICE - 1)) begin
          res_d   = work_d;
          z_d     = ~|zacc_d;
          n_d     = work_d[WIDTH-1];
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
          p_d     = ^work_d;
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      work_q  <= '0;
      zacc_q  <= '0;
      k_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
      p_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      work_q  <= work_d;
      zacc_q  <= zacc_d;
      k_q     <= k_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
      p_q     <= p_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign busy   = state_q[1];
  assign done   = state_q[2];
  assign result = res_q;
  assign Z      = z_q;
  assign N      = n_q;
  assign C      = 1'b0;
  assign V      = 1'b0;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
  assign P      = p_q;
`else
  assign P      = 1'b0;
`endif

endmodule
